inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit
//  Purpose  : RV32I fetch stage. Credit-limited word fetch from a valid/ready
//             memory with in-order responses. Fetched words are buffered in a
//             DEPTH-entry FIFO of {pc, word} for the core. Redirects discard
//             in-flight and buffered wrong-path words.
//  Options  : IFU_STALL_CNT_EN - builds the fetch-starve counter on stall_cnt
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ist,
    output logic [31:0] ist_pc,
    output logic        ist_valid,
    input  logic        ist_ready,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] stall_cnt
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W:0]   c_CREDIT   = (c_CNT_W + 1)'(DEPTH);

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_resp_pc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [31:0]        r_mem_pc   [DEPTH];
    logic [31:0]        r_mem_word [DEPTH];

    logic [31:0]        w_redirect_base;
    logic [c_CNT_W:0]   w_in_use;
    logic               w_accept;
    logic               w_resp;
    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_out_next;

    // Masking (rather than slicing) keeps every redirect_pc bit referenced.
    assign w_redirect_base = redirect_pc & 32'hFFFF_FFFC;

    // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
    assign w_in_use       = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req_valid = !reset && !redirect_valid && (w_in_use < c_CREDIT);
    assign imem_req_addr  = r_fetch_pc;

    assign w_accept  = imem_req_valid && imem_req_ready;
    assign w_resp    = imem_resp_valid && (r_outstanding != '0);
    assign w_push    = w_resp && (r_drop_cnt == '0) && !redirect_valid;
    assign ist_valid = (r_count != '0) && !redirect_valid;
    assign w_pop     = ist_valid && ist_ready;

    assign ist    = r_mem_word[r_rd_ptr];
    assign ist_pc = r_mem_pc[r_rd_ptr];

    always_comb begin
        w_out_next = r_outstanding;
        if (w_accept && !w_resp) begin
            w_out_next = r_outstanding + c_CNT_ONE;
        end else if (!w_accept && w_resp) begin
            w_out_next = r_outstanding - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_fetch_pc    <= w_redirect_base;
            r_resp_pc     <= w_redirect_base;
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_out_next;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_resp) begin
                if (r_drop_cnt != '0) begin
                    r_drop_cnt <= r_drop_cnt - c_CNT_ONE;
                end else begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]   <= '0;
                r_mem_word[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
            r_mem_word[r_wr_ptr] <= imem_resp_data;
        end
    end

`ifdef IFU_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Counts cycles the core wanted an instruction but none was available.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (ist_ready && !ist_valid && !redirect_valid) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_unit
//  Purpose  : Self-checking bench for inst_fetch_unit: variable-latency memory
//             model plus a scoreboard of expected {pc, word} deliveries.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam logic [31:0] c_RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] ist;
    logic [31:0] ist_pc;
    logic        ist_valid;
    logic        ist_ready = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    inst_fetch_unit #(.DEPTH(4), .RESET_PC(c_RST_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .ist             (ist),
        .ist_pc          (ist_pc),
        .ist_valid       (ist_valid),
        .ist_ready       (ist_ready),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stall_cnt       (stall_cnt)
    );

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [31:0] sb[$];
    int          cyc = 0;
    int          lat = 1;
    bit          mem_rdy = 1'b0;
    bit          core_rdy = 1'b0;
    bit          rd_req = 1'b0;
    logic [31:0] rd_pc = '0;
    int          first_pop = -1;
    int          last_pop = -1;
    int          n_pop = 0;
    int          n_acc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) sb.push_back(base + 32'(4 * i));
    endtask

    // Apply this cycle's inputs shortly after the falling edge.
    task automatic drive();
        redirect_valid = rd_req;
        redirect_pc    = rd_pc;
        imem_req_ready = mem_rdy;
        ist_ready      = core_rdy && (sb.size() != 0);
        if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr_q[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
        #1;
    endtask

    // Record the handshakes taken at the coming rising edge, score pops, advance.
    task automatic commit();
        logic [31:0] exp_pc;
        if (imem_resp_valid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cyc + lat);
            n_acc++;
        end
        if (ist_valid && ist_ready) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got ist_pc=%h ist=%h, expected no delivery", ist_pc, ist);
            end else begin
                exp_pc = sb.pop_front();
                if (ist_pc !== exp_pc || ist !== mem_word(exp_pc))
                    $display("FAIL sb_pop: got pc=%h ist=%h, expected pc=%h ist=%h",
                             ist_pc, ist, exp_pc, mem_word(exp_pc));
                else
                    pass_cnt++;
            end
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            n_pop++;
        end
        rd_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            commit();
        end
    endtask

    task automatic run_until_empty(input int max_cyc, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            drive();
            commit();
            n++;
        end
        total_cnt++;
        if (sb.size() != 0)
            $display("FAIL %s_drain: got %0d entries left after %0d cycles, expected 0", tag, sb.size(), max_cyc);
        else
            pass_cnt++;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        ist_ready       = 1'b0;
        rd_req          = 1'b0;
        mem_addr_q.delete();
        mem_due_q.delete();
        sb.delete();
        first_pop = -1;
        last_pop  = -1;
        n_pop     = 0;
        n_acc     = 0;
        lat       = 1;
        mem_rdy   = 1'b1;
        core_rdy  = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        cyc = 1;
    endtask

    task automatic test_reset();
        do_reset();
        push_seq(c_RST_PC, 3);
        run_cycles(5);
        // Assert reset between edges: state must clear without a clock.
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (ist_valid !== 1'b0) $display("FAIL rst_ist_valid: got %b, expected 0", ist_valid); else pass_cnt++;
        total_cnt++;
        if (ist !== 32'h0) $display("FAIL rst_ist: got %h, expected 0", ist); else pass_cnt++;
        total_cnt++;
        if (ist_pc !== 32'h0) $display("FAIL rst_ist_pc: got %h, expected 0", ist_pc); else pass_cnt++;
        total_cnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid); else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 32'h0) $display("FAIL rst_stall_cnt: got %h, expected 0", stall_cnt); else pass_cnt++;

        do_reset();
        mem_rdy = 1'b0;
        drive();
        total_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== c_RST_PC)
            $display("FAIL first_req: got valid=%b addr=%h, expected valid=1 addr=%h",
                     imem_req_valid, imem_req_addr, c_RST_PC);
        else pass_cnt++;
        commit();
    endtask

    task automatic test_stream();
        do_reset();
        push_seq(c_RST_PC, 12);
        run_until_empty(40, "stream");
        total_cnt++;
        if (first_pop !== 3) $display("FAIL stream_first_cycle: got %0d, expected 3", first_pop); else pass_cnt++;
        total_cnt++;
        if (last_pop - first_pop !== 11)
            $display("FAIL stream_throughput: got span %0d, expected 11", last_pop - first_pop);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        core_rdy = 1'b0;
        run_cycles(8);
        total_cnt++;
        if (n_acc !== 4) $display("FAIL bp_accepts: got %0d, expected 4", n_acc); else pass_cnt++;
        drive();
        total_cnt++;
        if (imem_req_valid !== 1'b0 || ist_valid !== 1'b1)
            $display("FAIL bp_full: got req_valid=%b ist_valid=%b, expected 0 and 1", imem_req_valid, ist_valid);
        else pass_cnt++;
        commit();
        core_rdy = 1'b1;
        push_seq(c_RST_PC, 8);
        run_until_empty(40, "bp");
        total_cnt++;
        if (n_acc < 8) $display("FAIL bp_resume: got %0d accepts, expected at least 8", n_acc); else pass_cnt++;
    endtask

    task automatic test_redirect_drop();
        do_reset();
        lat = 3;
        run_cycles(3);
        rd_req = 1'b1;
        rd_pc  = 32'h8000_0100;
        push_seq(32'h8000_0100, 6);
        drive();
        total_cnt++;
        if (imem_req_valid !== 1'b0 || ist_valid !== 1'b0)
            $display("FAIL drop_redirect_cycle: got req_valid=%b ist_valid=%b, expected 0 and 0",
                     imem_req_valid, ist_valid);
        else pass_cnt++;
        commit();
        run_until_empty(60, "drop");
    endtask

    task automatic test_redirect_unaligned();
        int n;
        do_reset();
        push_seq(c_RST_PC, 3);
        run_until_empty(20, "unal_pre");
        rd_req = 1'b1;
        rd_pc  = 32'h8000_0102;
        push_seq(32'h8000_0100, 4);
        first_pop = -1;
        n = cyc;
        drive();
        total_cnt++;
        if (ist_valid !== 1'b0) $display("FAIL unal_no_pop: got ist_valid=%b, expected 0", ist_valid); else pass_cnt++;
        commit();
        drive();
        total_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100)
            $display("FAIL unal_req: got valid=%b addr=%h, expected valid=1 addr=80000100",
                     imem_req_valid, imem_req_addr);
        else pass_cnt++;
        commit();
        run_until_empty(30, "unal");
        total_cnt++;
        if (first_pop !== n + 3) $display("FAIL unal_latency: got cycle %0d, expected %0d", first_pop, n + 3); else pass_cnt++;
    endtask

    task automatic test_redirect_collide();
        int pops;
        do_reset();
        push_seq(c_RST_PC, 20);
        run_cycles(6);
        sb.delete();
        push_seq(32'h8000_0200, 4);
        rd_req = 1'b1;
        rd_pc  = 32'h8000_0200;
        pops   = n_pop;
        drive();
        total_cnt++;
        if (ist_valid !== 1'b0 || imem_resp_valid !== 1'b1 || ist_ready !== 1'b1)
            $display("FAIL collide_cycle: got ist_valid=%b (resp=%b ready=%b), expected 0 (1,1)",
                     ist_valid, imem_resp_valid, ist_ready);
        else pass_cnt++;
        commit();
        drive();
        total_cnt++;
        if (ist_valid !== 1'b0 || n_pop !== pops)
            $display("FAIL collide_next: got ist_valid=%b pops=%0d, expected 0 and %0d", ist_valid, n_pop, pops);
        else pass_cnt++;
        commit();
        run_until_empty(30, "collide");
    endtask

    task automatic test_stall_cnt();
        logic [31:0] exp_stall;
`ifdef IFU_STALL_CNT_EN
        exp_stall = 32'd10;
`else
        exp_stall = 32'd0;
`endif
        do_reset();
        mem_rdy = 1'b0;
        push_seq(c_RST_PC, 1);
        run_cycles(10);
        total_cnt++;
        if (stall_cnt !== exp_stall) $display("FAIL stall_cnt: got %0d, expected %0d", stall_cnt, exp_stall); else pass_cnt++;
        total_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== c_RST_PC)
            $display("FAIL stall_req_held: got valid=%b addr=%h, expected valid=1 addr=%h",
                     imem_req_valid, imem_req_addr, c_RST_PC);
        else pass_cnt++;
        mem_rdy = 1'b1;
        run_until_empty(20, "stall");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_unaligned();
        test_redirect_collide();
        test_stall_cnt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
